mem_wb_stage: RTL

- MEM→WB pipeline register and writeback stage. It registers the MEM stage output (Result, load/store control, destination register) and performs load byte/halfword extraction with sign or zero extension.
- It drives the register-file write port, a forwarding tap for EX, a misalignment fault pulse, and a retired-instruction counter.
- It sits directly downstream of the MEM stage. It consumes the MEM Result (raw aligned 32-bit word for loads, ALU result otherwise) and the DStall signal.

---
 rtl/mem_wb_stage.sv | 118 +++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register and writeback stage: load extraction, register-file write port,
// misalignment fault pulse and retired-instruction counter.
module mem_wb_stage #(
  parameter int RETIRE_W   = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [31:0]           Result,
  input  logic [1:0]            AddrLo,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            LS_op,
  input  logic                  RegWrite,
  input  logic [REG_ADDR_W-1:0] Rd,
  input  logic                  DStall,
  input  logic                  Flush,
  output logic                  RfWe,
  output logic [REG_ADDR_W-1:0] RfWaddr,
  output logic [31:0]           RfWdata,
  output logic                  FwdValid,
  output logic                  MisalignExc,
  output logic [REG_ADDR_W-1:0] MisalignRd,
  output logic [RETIRE_W-1:0]   RetireCount
);

  logic                  vld_p1;
  logic [31:0]           result_p1;
  logic [1:0]            addr_lo_p1;
  logic [2:0]            ls_op_p1;
  logic                  mem_read_p1;
  logic                  mem_write_p1;
  logic                  reg_write_p1;
  logic [REG_ADDR_W-1:0] rd_p1;
  logic [REG_ADDR_W-1:0] waddr_p1;
  logic [RETIRE_W-1:0]   retire_cnt;
  logic                  accept;
  logic                  misaligned;

  function automatic logic [31:0] extract_load(input logic [31:0] w, input logic [1:0] o,
                                               input logic [2:0] op);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] bs;
    logic signed [31:0] hs;
    logic [31:0]        r;
    sh = w >> {o, 3'b000};
    b  = sh[7:0];
    h  = o[1] ? w[31:16] : w[15:0];
    bs = b;
    hs = h;
    case (op)
      3'b000:  r = bs;
      3'b100:  r = {24'd0, b};
      3'b001:  r = hs;
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Illegal load encodings fault exactly like misaligned accesses.
  function automatic logic is_misaligned(input logic [1:0] o, input logic [2:0] op);
    logic m;
    case (op)
      3'b000, 3'b100: m = 1'b0;
      3'b001, 3'b101: m = o[0];
      3'b010:         m = (o != 2'b00);
      default:        m = 1'b1;
    endcase
    return m;
  endfunction

  assign accept = in_valid & ~DStall & ~Flush;

  // ---- MEM -> WB boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1       <= 1'b0;
      result_p1    <= '0;
      addr_lo_p1   <= '0;
      ls_op_p1     <= '0;
      mem_read_p1  <= 1'b0;
      mem_write_p1 <= 1'b0;
      reg_write_p1 <= 1'b0;
      rd_p1        <= '0;
      waddr_p1     <= '0;
    end else begin
      vld_p1       <= accept;
      result_p1    <= Result;
      addr_lo_p1   <= AddrLo;
      ls_op_p1     <= LS_op;
      mem_read_p1  <= MemRead;
      mem_write_p1 <= MemWrite;
      reg_write_p1 <= RegWrite;
      rd_p1        <= Rd;
      if (accept) waddr_p1 <= Rd;
    end
  end

  assign misaligned = mem_read_p1 & is_misaligned(addr_lo_p1, ls_op_p1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         retire_cnt <= '0;
    else if (vld_p1 && !misaligned)  retire_cnt <= retire_cnt + RETIRE_W'(1);
  end

  assign RfWe        = vld_p1 & reg_write_p1 & ~mem_write_p1 & (rd_p1 != '0) & ~misaligned;
  assign FwdValid    = RfWe;
  assign RfWaddr     = waddr_p1;
  assign RfWdata     = mem_read_p1 ? extract_load(result_p1, addr_lo_p1, ls_op_p1) : result_p1;
  assign MisalignExc = vld_p1 & misaligned;
  assign MisalignRd  = MisalignExc ? rd_p1 : '0;
  assign RetireCount = retire_cnt;

endmodule
